// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcode constants, step indices and control vector layout
package control_unit_pkg;
    localparam int OP_W   = 4;
    localparam int STEP_W = 3;
    localparam int LAST_T = 4;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    typedef enum logic [OP_W-1:0] {
        OP_LDA = 4'h0,
        OP_STA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_LDI = 4'h4,
        OP_BRC = 4'h5,
        OP_BRZ = 4'h6,
        OP_JMP = 4'h7,
        OP_OUT = 4'h8,
        OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic jmp;
        logic mar_in;
        logic ram_out;
        logic ram_in;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
        logic out_in;
    } ctrl_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational (step, opcode) to raw control vector
module control_decode
    import control_unit_pkg::*;
(
    input  logic [STEP_W-1:0] step_i,
    input  logic [OP_W-1:0]   op_i,
    output ctrl_t             ctrl_o
);
    // Fetch steps ignore the opcode; execute steps decode it, unknown opcodes are NOPs
    always_comb begin
        ctrl_o = '0;
        case (step_i)
            T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
            end
            T1: begin
                ctrl_o.ram_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
                ctrl_o.pc_inc  = 1'b1;
            end
            T2: case (op_i)
                OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                    ctrl_o.ir_out = 1'b1;
                    ctrl_o.mar_in = 1'b1;
                end
                OP_LDI: begin
                    ctrl_o.ir_out = 1'b1;
                    ctrl_o.a_in   = 1'b1;
                end
                OP_BRC, OP_BRZ, OP_JMP: begin
                    ctrl_o.ir_out = 1'b1;
                    ctrl_o.jmp    = 1'b1;
                end
                OP_OUT: begin
                    ctrl_o.a_out  = 1'b1;
                    ctrl_o.out_in = 1'b1;
                end
                default: ;
            endcase
            T3: case (op_i)
                OP_LDA: begin
                    ctrl_o.ram_out = 1'b1;
                    ctrl_o.a_in    = 1'b1;
                end
                OP_STA: begin
                    ctrl_o.a_out  = 1'b1;
                    ctrl_o.ram_in = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    ctrl_o.ram_out = 1'b1;
                    ctrl_o.b_in    = 1'b1;
                end
                default: ;
            endcase
            T4: if (op_i == OP_ADD || op_i == OP_SUB) begin
                ctrl_o.alu_out  = 1'b1;
                ctrl_o.a_in     = 1'b1;
                ctrl_o.flags_in = 1'b1;
                ctrl_o.alu_sub  = (op_i == OP_SUB);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: five-step sequencer with halt latch and run/halt/reset output gating
module control_unit
    import control_unit_pkg::*;
#(
    parameter int OP_WIDTH  = OP_W,
    parameter int LAST_STEP = LAST_T
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic [OP_WIDTH-1:0] op_i,
    output logic                ctrl_pc_out_o,
    output logic                ctrl_pc_inc_o,
    output logic                ctrl_jmp_o,
    output logic                ctrl_mar_in_o,
    output logic                ctrl_ram_out_o,
    output logic                ctrl_ram_in_o,
    output logic                ctrl_ir_in_o,
    output logic                ctrl_ir_out_o,
    output logic                ctrl_a_in_o,
    output logic                ctrl_a_out_o,
    output logic                ctrl_b_in_o,
    output logic                ctrl_alu_out_o,
    output logic                ctrl_alu_sub_o,
    output logic                ctrl_flags_in_o,
    output logic                ctrl_out_in_o,
    output logic [STEP_W-1:0]   step_o,
    output logic                halted_o
);
    logic [STEP_W-1:0] r_step;
    logic              r_halted;
    logic              w_gate;
    ctrl_t             w_raw;

    control_decode u_decode (
        .step_i (r_step),
        .op_i   (op_i),
        .ctrl_o (w_raw)
    );

    // Step counter and halt latch; HLT freezes the counter at T2 instead of advancing
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (run_i && !r_halted) begin
            if (r_step == T2 && op_i == OP_HLT)
                r_halted <= 1'b1;
            else
                r_step <= (r_step == STEP_W'(LAST_STEP)) ? T0 : r_step + STEP_W'(1);
        end
    end

    assign w_gate          = run_i & ~r_halted & ~rst_i;
    assign ctrl_pc_out_o   = w_raw.pc_out   & w_gate;
    assign ctrl_pc_inc_o   = w_raw.pc_inc   & w_gate;
    assign ctrl_jmp_o      = w_raw.jmp      & w_gate;
    assign ctrl_mar_in_o   = w_raw.mar_in   & w_gate;
    assign ctrl_ram_out_o  = w_raw.ram_out  & w_gate;
    assign ctrl_ram_in_o   = w_raw.ram_in   & w_gate;
    assign ctrl_ir_in_o    = w_raw.ir_in    & w_gate;
    assign ctrl_ir_out_o   = w_raw.ir_out   & w_gate;
    assign ctrl_a_in_o     = w_raw.a_in     & w_gate;
    assign ctrl_a_out_o    = w_raw.a_out    & w_gate;
    assign ctrl_b_in_o     = w_raw.b_in     & w_gate;
    assign ctrl_alu_out_o  = w_raw.alu_out  & w_gate;
    assign ctrl_alu_sub_o  = w_raw.alu_sub  & w_gate;
    assign ctrl_flags_in_o = w_raw.flags_in & w_gate;
    assign ctrl_out_in_o   = w_raw.out_in   & w_gate;
    assign step_o          = r_step;
    assign halted_o        = r_halted;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed checks of control_unit against a table-driven model
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [3:0] op  = 4'h0;
    logic pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted;
    logic [2:0] step;
    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt   = 0;
    bit m_halt  = 1'b0;
    logic [14:0] tab [16][3];

    localparam logic [14:0] PCO  = 15'h4000, PCI  = 15'h2000, JMP  = 15'h1000, MARI = 15'h0800;
    localparam logic [14:0] RAMO = 15'h0400, RAMI = 15'h0200, IRI  = 15'h0100, IRO  = 15'h0080;
    localparam logic [14:0] AI   = 15'h0040, AO   = 15'h0020, BI   = 15'h0010, ALUO = 15'h0008;
    localparam logic [14:0] SUBS = 15'h0004, FLG  = 15'h0002, OUTI = 15'h0001;

    wire [14:0] ctrl = {pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out,
                        a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};

    control_unit dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .op_i(op),
        .ctrl_pc_out_o(pc_out), .ctrl_pc_inc_o(pc_inc), .ctrl_jmp_o(jmp),
        .ctrl_mar_in_o(mar_in), .ctrl_ram_out_o(ram_out), .ctrl_ram_in_o(ram_in),
        .ctrl_ir_in_o(ir_in), .ctrl_ir_out_o(ir_out), .ctrl_a_in_o(a_in),
        .ctrl_a_out_o(a_out), .ctrl_b_in_o(b_in), .ctrl_alu_out_o(alu_out),
        .ctrl_alu_sub_o(alu_sub), .ctrl_flags_in_o(flags_in), .ctrl_out_in_o(out_in),
        .step_o(step), .halted_o(halted)
    );

    always #5 clk = ~clk;

    // Model: count of completed micro-steps; the step is that count modulo five
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_halt <= 1'b0;
        end else if (run && !m_halt) begin
            if (m_cnt % 5 == 2 && op == 4'hF) m_halt <= 1'b1;
            else m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [14:0] exp_ctrl();
        int s = m_cnt % 5;
        if (rst || !run || m_halt) return '0;
        if (s == 0) return PCO | MARI;
        if (s == 1) return RAMO | IRI | PCI;
        return tab[op][s-2];
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic go(int s);
        for (int i = 0; i < 12 && int'(step) != s; i++) @(negedge clk);
        chk("reach_step", 32'(step), 32'(s));
    endtask

    // Continuous comparison of every output against the model, mid low phase
    always @(negedge clk) begin
        #2;
        if (rst || n_tests > 0) begin
            chk("ctrl", 32'(ctrl), 32'(exp_ctrl()));
            chk("step", 32'(step), 32'(rst ? 0 : m_cnt % 5));
            chk("halted", 32'(halted), 32'(m_halt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int o = 0; o < 16; o++)
            for (int k = 0; k < 3; k++) tab[o][k] = '0;
        tab[0][0] = IRO | MARI;  tab[0][1] = RAMO | AI;
        tab[1][0] = IRO | MARI;  tab[1][1] = AO | RAMI;
        tab[2][0] = IRO | MARI;  tab[2][1] = RAMO | BI;  tab[2][2] = ALUO | AI | FLG;
        tab[3][0] = IRO | MARI;  tab[3][1] = RAMO | BI;  tab[3][2] = ALUO | AI | FLG | SUBS;
        tab[4][0] = IRO | AI;
        tab[5][0] = IRO | JMP;   tab[6][0] = IRO | JMP;  tab[7][0] = IRO | JMP;
        tab[8][0] = AO | OUTI;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_ctrl", 32'(ctrl), 32'(0));
        chk("rst_step", 32'(step), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        @(negedge clk); rst = 1'b0; run = 1'b1; op = 4'h0;
        #3 chk("lda_t0", 32'(ctrl), 32'(PCO | MARI));
        @(negedge clk); #3 chk("lda_t1", 32'(ctrl), 32'(RAMO | IRI | PCI));
        @(negedge clk); #3 chk("lda_t2", 32'(ctrl), 32'(IRO | MARI));
        @(negedge clk); #3 chk("lda_t3", 32'(ctrl), 32'(RAMO | AI));
        @(negedge clk); #3 chk("lda_t4", 32'(ctrl), 32'(0));
        chk("lda_step4", 32'(step), 32'(4));
        @(negedge clk); op = 4'h3;
        #3 chk("wrap_step", 32'(step), 32'(0));
        go(4); #3 chk("sub_t4", 32'(ctrl), 32'(ALUO | AI | FLG | SUBS));
        go(0); op = 4'h6;
        go(2); #3 chk("brz_t2", 32'(ctrl), 32'(IRO | JMP));
        @(negedge clk); #3 chk("brz_t3", 32'(jmp), 32'(0));
        go(0); op = 4'h7;
        go(2); #3 chk("jmp_t2", 32'(jmp), 32'(1));
        go(0); op = 4'hA;
        go(2); #3 chk("nop_t2", 32'(ctrl), 32'(0));
        go(4); #3 chk("nop_t4", 32'(ctrl), 32'(0));
        go(0); op = 4'h2;
        go(3); run = 1'b0;
        #3 chk("pause_ctrl", 32'(ctrl), 32'(0));
        repeat (2) @(negedge clk);
        #3 chk("pause_step", 32'(step), 32'(3));
        @(negedge clk); run = 1'b1;
        #3 chk("resume_t3", 32'(ctrl), 32'(RAMO | BI));
        @(negedge clk); #3 chk("resume_t4", 32'(ctrl), 32'(ALUO | AI | FLG));
        repeat (400) begin
            @(negedge clk);
            if (m_cnt % 5 < 2) op = 4'($urandom_range(0, 14));
            run = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); run = 1'b1;
        go(0); op = 4'hF;
        go(2); run = 1'b0;
        repeat (2) @(negedge clk);
        #3 chk("hlt_norun_halted", 32'(halted), 32'(0));
        chk("hlt_norun_step", 32'(step), 32'(2));
        @(negedge clk); run = 1'b1;
        @(negedge clk); #3 chk("hlt_halted", 32'(halted), 32'(1));
        chk("hlt_ctrl", 32'(ctrl), 32'(0));
        repeat (3) @(negedge clk);
        #3 chk("hlt_frozen", 32'(step), 32'(2));
        @(negedge clk); rst = 1'b1;
        #3 chk("hlt_rst_halted", 32'(halted), 32'(0));
        chk("hlt_rst_step", 32'(step), 32'(0));
        @(negedge clk); rst = 1'b0; op = 4'h0;
        go(3);
        #1 rst = 1'b1;
        #1 chk("async_ctrl", 32'(ctrl), 32'(0));
        chk("async_step", 32'(step), 32'(0));
        @(negedge clk); rst = 1'b0;
        #3 chk("restart_t0", 32'(ctrl), 32'(PCO | MARI));
        @(negedge clk); #3 chk("restart_t1", 32'(step), 32'(1));
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
